bbox_detect: RTL and testbench
==============================

Name: bbox_detect

Overview:
- Scans the full source image in byte-addressed memory and classifies each pixel as foreground or background by thresholding the sum of its three channel bytes.
- Reports the tight bounding box (xMin/xMax/yMin/yMax) of all foreground pixels.
- Sits directly upstream of the cropping stage and drives its bounds inputs; done from this block gates start of the cropper.

Parameters:
- WIDTH, 100, source image width in pixels (1..2047)
- HEIGHT, 100, source image height in pixels (1..2047)
- BASE_ADDR, 0, byte address of the first pixel byte of the bottom stored row
- ROW_STRIDE, 300, bytes per stored row (3*WIDTH by default, may include padding)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin scan; sampled in IDLE or DONE only
- thresh  in  10  foreground threshold; captured when start is accepted
- readAddr  out  32  byte read address to source memory
- readdata  in  16  read data; only [7:0] used, valid the cycle after readAddr is presented
- done  out  1  high while in DONE
- found  out  1  at least one foreground pixel in last scan
- xMin, xMax  out  11  bounding box columns, inclusive
- yMin, yMax  out  11  bounding box rows, inclusive, y=0 is top image row

Behaviour:
- Reset (async, rst_n=0): state IDLE, done=0, found=0, xMin=0, xMax=WIDTH-1, yMin=0, yMax=HEIGHT-1, counters x=y=c=0. Reset mid-scan aborts immediately and leaves no partial result.
- States: IDLE, REQ, CAP, DONE.
- IDLE/DONE: if start=1, capture thresh, clear x, y, c, acc and anyFg, then go to REQ. Otherwise hold. start in REQ/CAP is ignored.
- readAddr is combinational from the counters at all times: BASE_ADDR + (HEIGHT-1-y)*ROW_STRIDE + 3*x + c, with c=0 B, 1 G, 2 R. Rows are stored bottom-up.
- REQ: address is presented; go to CAP.
- CAP: add readdata[7:0] to a 10-bit channel accumulator. If c<2, c++ and go to REQ. If c=2, form sum = acc + readdata[7:0] combinationally.
  - fg = (sum >= thresh).
  - If fg and !anyFg: working bounds = x, x, y, y; set anyFg.
  - If fg and anyFg: update min/max per axis.
  - Then clear acc and c, and advance x; at x=WIDTH-1 wrap x to 0 and increment y.
  - At x=WIDTH-1 and y=HEIGHT-1, go to DONE instead and latch outputs.
- Output latch on entering DONE: if anyFg, found=1 and outputs = working bounds. Otherwise found=0 and outputs = full frame (0, WIDTH-1, 0, HEIGHT-1), so the cropper passes the whole image.
- Outputs are stable from the cycle done rises until the next scan completes. Outputs hold their previous values during a scan.
- Timing:
  - 6 cycles per pixel.
  - start accepted at edge T; REQ from T+1; done=1 from edge T+6*WIDTH*HEIGHT.
  - done stays high until start is accepted, then drops the next cycle.
- Width rules:
  - Sum of 3 bytes ≤ 765 fits 10 bits, no overflow.
  - x, y are 11 bits; address arithmetic is 32 bits.
  - thresh=0 makes every pixel foreground.
  - thresh > 765 makes no pixel foreground.
- WIDTH=1 or HEIGHT=1 is legal; min equals max on that axis.

Test Plan (WIDTH=8, HEIGHT=6, ROW_STRIDE=24, BASE_ADDR=0, background bytes 0):
- Single pixel (3,2) = FF,FF,FF, thresh=100 -> found=1, x 3..3, y 2..2; done rises exactly 288 cycles after start is sampled.
- Foreground rectangle x 1..5, y 2..4 (each byte 0x40, sum 192), thresh=192 -> found=1, bounds 1,5,2,4. Rerun with thresh=193 -> found=0, bounds 0,7,0,5.
- All-zero image, thresh=1 -> found=0, xMin=0, xMax=7, yMin=0, yMax=5. thresh=0 -> found=1, bounds 0,7,0,5.
- Address trace:
  - First read (0,0,B) = 120, next (0,0,G) = 121.
  - First read of pixel (1,0) = 123.
  - Last read (7,5,R) = 23.
  - Each address is held for its REQ/CAP pair.
- Reset mid-scan (rst_n low 2 cycles at cycle 100) -> done=0, found=0, bounds full frame immediately. A restart with the single-pixel image gives 3,3,2,2.
- start pulsed during scan -> ignored, done timing unchanged. start while in DONE -> done low next cycle, new scan results replace old ones.

Source files
------------

// File: rtl/bbox_detect.sv
// Raster-scans a 3-byte-per-pixel image, thresholds each pixel's channel sum and
// reports the tight bounding box of foreground pixels (full frame when none).
module bbox_detect #(
  parameter int unsigned WIDTH      = 100,
  parameter int unsigned HEIGHT     = 100,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned ROW_STRIDE = 300
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  thresh,
  output logic [31:0] readAddr,
  input  logic [15:0] readdata,
  output logic        done,
  output logic        found,
  output logic [10:0] xMin,
  output logic [10:0] xMax,
  output logic [10:0] yMin,
  output logic [10:0] yMax
);

  localparam int unsigned CW = 11;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = 10;
  localparam logic [CW-1:0] X_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, REQ, CAP, DONE} state_t;

  state_t        state, stateNext;
  logic [CW-1:0] x, xNext, y, yNext;
  logic [1:0]    c, cNext;
  logic [SW-1:0] acc, accNext, threshR, threshNext, sum;
  logic          anyFg, anyFgNext, fg;
  logic [CW-1:0] wxMin, wxMinNext, wxMax, wxMaxNext, wyMin, wyMinNext, wyMax, wyMaxNext;
  logic          doneNext, foundNext;
  logic [CW-1:0] xMinNext, xMaxNext, yMinNext, yMaxNext;
  logic          unusedHi;

  assign unusedHi = ^readdata[15:8];

  // Rows are stored bottom-up, so image row y lives at stored row HEIGHT-1-y.
  assign readAddr = AW'(BASE_ADDR) + (AW'(HEIGHT - 1) - AW'(y)) * AW'(ROW_STRIDE)
                  + AW'(3) * AW'(x) + AW'(c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      c       <= '0;
      acc     <= '0;
      threshR <= '0;
      anyFg   <= 1'b0;
      wxMin   <= '0;
      wxMax   <= '0;
      wyMin   <= '0;
      wyMax   <= '0;
      done    <= 1'b0;
      found   <= 1'b0;
      xMin    <= '0;
      xMax    <= X_LAST;
      yMin    <= '0;
      yMax    <= Y_LAST;
    end else begin
      state   <= stateNext;
      x       <= xNext;
      y       <= yNext;
      c       <= cNext;
      acc     <= accNext;
      threshR <= threshNext;
      anyFg   <= anyFgNext;
      wxMin   <= wxMinNext;
      wxMax   <= wxMaxNext;
      wyMin   <= wyMinNext;
      wyMax   <= wyMaxNext;
      done    <= doneNext;
      found   <= foundNext;
      xMin    <= xMinNext;
      xMax    <= xMaxNext;
      yMin    <= yMinNext;
      yMax    <= yMaxNext;
    end
  end

  always_comb begin
    stateNext  = state;
    xNext      = x;
    yNext      = y;
    cNext      = c;
    accNext    = acc;
    threshNext = threshR;
    anyFgNext  = anyFg;
    wxMinNext  = wxMin;
    wxMaxNext  = wxMax;
    wyMinNext  = wyMin;
    wyMaxNext  = wyMax;
    doneNext   = done;
    foundNext  = found;
    xMinNext   = xMin;
    xMaxNext   = xMax;
    yMinNext   = yMin;
    yMaxNext   = yMax;
    sum        = acc + SW'(readdata[7:0]);
    fg         = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          threshNext = thresh;
          xNext      = '0;
          yNext      = '0;
          cNext      = '0;
          accNext    = '0;
          anyFgNext  = 1'b0;
          doneNext   = 1'b0;
          stateNext  = REQ;
        end
      end
      REQ: stateNext = CAP;
      CAP: begin
        stateNext = REQ;
        if (c != 2'd2) begin
          accNext = sum;
          cNext   = c + 2'd1;
        end else begin
          fg      = (sum >= threshR);
          accNext = '0;
          cNext   = '0;
          if (fg && !anyFg) begin
            wxMinNext = x;
            wxMaxNext = x;
            wyMinNext = y;
            wyMaxNext = y;
            anyFgNext = 1'b1;
          end else if (fg) begin
            if (x < wxMin) wxMinNext = x;
            if (x > wxMax) wxMaxNext = x;
            if (y < wyMin) wyMinNext = y;
            if (y > wyMax) wyMaxNext = y;
          end
          if (x != X_LAST) begin
            xNext = x + CW'(1);
          end else if (y != Y_LAST) begin
            xNext = '0;
            yNext = y + CW'(1);
          end else begin
            // Last pixel: publish bounds including this pixel's contribution.
            stateNext = DONE;
            doneNext  = 1'b1;
            foundNext = anyFgNext;
            if (anyFgNext) begin
              xMinNext = wxMinNext;
              xMaxNext = wxMaxNext;
              yMinNext = wyMinNext;
              yMaxNext = wyMaxNext;
            end else begin
              xMinNext = '0;
              xMaxNext = X_LAST;
              yMinNext = '0;
              yMaxNext = Y_LAST;
            end
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bbox_detect.sv
// Scoreboard bench for bbox_detect on an 8x6 image: expected boxes come from a
// pixel-array model pushed at scan start and popped when done rises.
module tb_bbox_detect;

  localparam int W      = 8;
  localparam int H      = 6;
  localparam int STRIDE = 24;
  localparam int MEMSZ  = STRIDE * H;
  localparam int SCAN   = 6 * W * H;

  typedef struct packed {
    logic        found;
    logic [10:0] xMin;
    logic [10:0] xMax;
    logic [10:0] yMin;
    logic [10:0] yMax;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  thresh = '0;
  logic [31:0] readAddr;
  logic [15:0] readdata = '0;
  logic        done, found;
  logic [10:0] xMin, xMax, yMin, yMax;

  logic [7:0]  mem [0:MEMSZ-1];
  logic [7:0]  pix [0:H-1][0:W-1][0:2];
  logic [31:0] addrLog [0:399];
  res_t        expQ[$];
  res_t        lastRes;
  int          tests = 0;
  int          fails = 0;

  bbox_detect #(.WIDTH(W), .HEIGHT(H), .BASE_ADDR(0), .ROW_STRIDE(STRIDE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .thresh(thresh),
    .readAddr(readAddr), .readdata(readdata), .done(done), .found(found),
    .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (readAddr < 32'(MEMSZ)) readdata <= {8'h00, mem[readAddr[7:0]]};
    else readdata <= 16'h0000;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic res_t fullFrame();
    res_t r;
    r.found = 1'b0; r.xMin = 11'd0; r.xMax = 11'(W - 1); r.yMin = 11'd0; r.yMax = 11'(H - 1);
    return r;
  endfunction

  task automatic clear_image();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int c = 0; c < 3; c++) pix[y][x][c] = 8'h00;
  endtask

  task automatic set_pixel(input int x, input int y, input logic [7:0] b, input logic [7:0] g,
                           input logic [7:0] r);
    pix[y][x][0] = b; pix[y][x][1] = g; pix[y][x][2] = r;
  endtask

  // Bottom-up storage: image row y is stored row H-1-y.
  task automatic load_mem();
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'h00;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int c = 0; c < 3; c++) mem[(H - 1 - y) * STRIDE + 3 * x + c] = pix[y][x][c];
  endtask

  task automatic push_model(input int thr);
    res_t r;
    bit any = 0;
    r = fullFrame();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (int'(pix[y][x][0]) + int'(pix[y][x][1]) + int'(pix[y][x][2]) >= thr) begin
          if (!any) begin
            r.xMin = 11'(x); r.xMax = 11'(x); r.yMin = 11'(y); r.yMax = 11'(y);
          end else begin
            if (11'(x) < r.xMin) r.xMin = 11'(x);
            if (11'(x) > r.xMax) r.xMax = 11'(x);
            if (11'(y) < r.yMin) r.yMin = 11'(y);
            if (11'(y) > r.yMax) r.yMax = 11'(y);
          end
          any = 1;
        end
    r.found = any;
    expQ.push_back(r);
  endtask

  // Starts a scan, logs addresses, pops the expected box when done rises.
  task automatic run_scan(input string name, input int thr, input int pulseAt, output int cyc);
    res_t e, got;
    load_mem();
    push_model(thr);
    @(negedge clk); start = 1'b1; thresh = 10'(thr);
    @(negedge clk); start = 1'b0; cyc = 0; addrLog[0] = readAddr;
    tests++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL %s done_drop: done=%0b required 0", name, done);
    end
    while (!done && cyc < 400) begin
      @(negedge clk); cyc++;
      start = (cyc == pulseAt) ? 1'b1 : 1'b0;
      if (cyc < 400) addrLog[cyc] = readAddr;
      if (cyc == 100) begin
        got = {found, xMin, xMax, yMin, yMax};
        tests++;
        if (got !== lastRes) begin
          fails++; $display("FAIL %s hold: outputs=%h required %h", name, got, lastRes);
        end
      end
    end
    start = 1'b0;
    tests++;
    if (cyc != SCAN) begin
      fails++; $display("FAIL %s latency: done after %0d cycles required %0d", name, cyc, SCAN);
    end
    e = expQ.pop_front();
    got = {found, xMin, xMax, yMin, yMax};
    tests++;
    if (got !== e) begin
      fails++;
      $display("FAIL %s result: found=%0b box=%0d,%0d,%0d,%0d required found=%0b box=%0d,%0d,%0d,%0d",
               name, got.found, got.xMin, got.xMax, got.yMin, got.yMax,
               e.found, e.xMin, e.xMax, e.yMin, e.yMax);
    end
    lastRes = e;
  endtask

  task automatic test_reset();
    res_t got;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    got = {found, xMin, xMax, yMin, yMax};
    tests++;
    if (got !== fullFrame() || done !== 1'b0) begin
      fails++; $display("FAIL reset_state: done=%0b outputs=%h required done=0 %h", done, got, fullFrame());
    end
    rst_n = 1'b1;
    lastRes = fullFrame();
  endtask

  task automatic test_single_pixel();
    int cyc, bad;
    clear_image();
    set_pixel(3, 2, 8'hFF, 8'hFF, 8'hFF);
    run_scan("single_pixel", 100, 0, cyc);
    tests++;
    if (addrLog[0] !== 32'd120 || addrLog[2] !== 32'd121) begin
      fails++; $display("FAIL addr_first: got %0d,%0d required 120,121", addrLog[0], addrLog[2]);
    end
    tests++;
    if (addrLog[6] !== 32'd123) begin
      fails++; $display("FAIL addr_pixel1: got %0d required 123", addrLog[6]);
    end
    tests++;
    if (addrLog[SCAN-2] !== 32'd23) begin
      fails++; $display("FAIL addr_last: got %0d required 23", addrLog[SCAN-2]);
    end
    bad = 0;
    for (int k = 0; k < SCAN / 2; k++) if (addrLog[2*k] !== addrLog[2*k+1]) bad++;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL addr_hold: %0d REQ/CAP pairs changed address, required 0", bad);
    end
  endtask

  task automatic test_rect();
    int cyc;
    clear_image();
    for (int y = 2; y <= 4; y++)
      for (int x = 1; x <= 5; x++) set_pixel(x, y, 8'h40, 8'h40, 8'h40);
    run_scan("rect_t192", 192, 0, cyc);
    run_scan("rect_t193", 193, 0, cyc);
  endtask

  task automatic test_zero();
    int cyc;
    clear_image();
    run_scan("zero_t1", 1, 0, cyc);
    run_scan("zero_t0", 0, 0, cyc);
    run_scan("zero_t1023", 1023, 0, cyc);
  endtask

  task automatic test_reset_mid();
    res_t got;
    int cyc;
    clear_image();
    for (int y = 2; y <= 4; y++)
      for (int x = 1; x <= 5; x++) set_pixel(x, y, 8'h40, 8'h40, 8'h40);
    load_mem();
    @(negedge clk); start = 1'b1; thresh = 10'd192;
    @(negedge clk); start = 1'b0;
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    #1;
    got = {found, xMin, xMax, yMin, yMax};
    tests++;
    if (got !== fullFrame() || done !== 1'b0) begin
      fails++; $display("FAIL reset_mid: done=%0b outputs=%h required done=0 %h", done, got, fullFrame());
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lastRes = fullFrame();
    clear_image();
    set_pixel(3, 2, 8'hFF, 8'hFF, 8'hFF);
    run_scan("restart", 100, 0, cyc);
  endtask

  task automatic test_start_during_scan();
    int cyc;
    clear_image();
    for (int y = 2; y <= 4; y++)
      for (int x = 1; x <= 5; x++) set_pixel(x, y, 8'h40, 8'h40, 8'h40);
    run_scan("start_in_scan", 192, 50, cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    tests++;
    if (done !== 1'b1) begin
      fails++; $display("FAIL b2b_precond: done=%0b required 1", done);
    end
    clear_image();
    set_pixel(0, 5, 8'h10, 8'h20, 8'h30);
    set_pixel(7, 0, 8'h30, 8'h20, 8'h10);
    run_scan("back_to_back", 96, 0, cyc);
  endtask

  initial begin
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'h00;
    test_reset();
    test_single_pixel();
    test_rect();
    test_zero();
    test_reset_mid();
    test_start_during_scan();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
